// File: rtl/posit_decoder_pipe.sv
// posit_decoder_pipe: two-stage posit field decoder (sign, scale, fraction, zero/NaR)
// with valid/ready flow control; S1 takes the absolute value, S2 decodes regime/exponent/fraction.
module posit_decoder_pipe #(
    parameter int N  = 8,
    parameter int ES = 0,
    localparam int FW = N - 3 - ES,
    localparam int SW = $clog2(N) + ES + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_posit,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          out_sign,
    output logic [SW-1:0] out_scale,
    output logic [FW-1:0] out_frac,
    output logic          out_zero,
    output logic          out_nar,
    output logic          out_valid,
    input  logic          out_ready
);
    localparam int MW = $clog2(N) + 1;

    logic                 s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d;
    logic                 s1_zero_q, s1_zero_d, s1_nar_q, s1_nar_d;
    logic [N-1:0]         s1_abs_q, s1_abs_d;
    logic                 out_valid_q, out_valid_d, out_sign_q, out_sign_d;
    logic                 out_zero_q, out_zero_d, out_nar_q, out_nar_d;
    logic [SW-1:0]        out_scale_q, out_scale_d;
    logic [FW-1:0]        out_frac_q, out_frac_d;
    logic                 s2_adv, s1_adv, r, stop, special;
    logic [MW-1:0]        run;
    logic [N-1:0]         rest;
    logic signed [SW-1:0] k, scale;

    assign s2_adv   = ~out_valid_q | out_ready;
    assign s1_adv   = ~s1_valid_q | s2_adv;
    assign in_ready = s1_adv;

    always_comb begin
        s1_valid_d = s1_adv ? in_valid : s1_valid_q;
        s1_sign_d  = s1_adv ? in_posit[N-1] : s1_sign_q;
        s1_abs_d   = s1_adv ? (in_posit[N-1] ? -in_posit : in_posit) : s1_abs_q;
        s1_zero_d  = s1_adv ? (in_posit == '0) : s1_zero_q;
        s1_nar_d   = s1_adv ? (in_posit == {1'b1, {(N-1){1'b0}}}) : s1_nar_q;
    end

    // Leading-run counter: run stops growing at the first bit that differs from the regime bit.
    always_comb begin
        r    = s1_abs_q[N-2];
        run  = MW'(1);
        stop = 1'b0;
        for (int i = N - 3; i >= 0; i--) begin
            stop = stop | (s1_abs_q[i] != r);
            run  = run + MW'(!stop);
        end
        rest  = s1_abs_q << (run + MW'(2));
        k     = r ? SW'(run) - SW'(1) : -SW'(run);
        scale = (k <<< ES) + SW'(rest >> (N - ES));
    end

    always_comb begin
        special     = s1_zero_q | s1_nar_q;
        out_valid_d = s2_adv ? s1_valid_q : out_valid_q;
        out_sign_d  = s2_adv ? s1_sign_q : out_sign_q;
        out_zero_d  = s2_adv ? s1_zero_q : out_zero_q;
        out_nar_d   = s2_adv ? s1_nar_q : out_nar_q;
        out_scale_d = s2_adv ? (special ? '0 : scale) : out_scale_q;
        out_frac_d  = s2_adv ? (special ? '0 : rest[N-1-ES -: FW]) : out_frac_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_sign_q   <= 1'b0;
            s1_abs_q    <= '0;
            s1_zero_q   <= 1'b0;
            s1_nar_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sign_q  <= 1'b0;
            out_scale_q <= '0;
            out_frac_q  <= '0;
            out_zero_q  <= 1'b0;
            out_nar_q   <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_sign_q   <= s1_sign_d;
            s1_abs_q    <= s1_abs_d;
            s1_zero_q   <= s1_zero_d;
            s1_nar_q    <= s1_nar_d;
            out_valid_q <= out_valid_d;
            out_sign_q  <= out_sign_d;
            out_scale_q <= out_scale_d;
            out_frac_q  <= out_frac_d;
            out_zero_q  <= out_zero_d;
            out_nar_q   <= out_nar_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_sign  = out_sign_q;
    assign out_scale = out_scale_q;
    assign out_frac  = out_frac_q;
    assign out_zero  = out_zero_q;
    assign out_nar   = out_nar_q;
endmodule

// File: tb/tb_posit_decoder_pipe.sv
// tb_posit_decoder_pipe: checks an 8-bit/ES=0 and a 16-bit/ES=1 decoder against a bit-walking
// posit model, with backpressure, stall stability, in_ready and mid-stream reset checks.
module tb_posit_decoder_pipe;
    typedef struct {
        bit     sign;
        int     scale;
        longint frac;
        bit     zero;
        bit     nar;
        int     cyc;
        bit     strict;
    } dec_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  a_in;
    logic        a_iv, a_ir, a_ov, a_or, a_sign, a_zero, a_nar;
    logic [3:0]  a_scale;
    logic [4:0]  a_frac;
    logic [15:0] b_in;
    logic        b_iv, b_ir, b_ov, b_or, b_sign, b_zero, b_nar;
    logic [5:0]  b_scale;
    logic [11:0] b_frac;

    int     nchk = 0, nerr = 0, cyc = 0;
    bit     strict = 1'b1, rand_or = 1'b0, held8 = 1'b0;
    longint prev8;
    dec_t   q8[$], q16[$];
    dec_t   pin;

    posit_decoder_pipe #(.N(8), .ES(0)) dut8 (
        .clk(clk), .rst(rst), .in_posit(a_in), .in_valid(a_iv), .in_ready(a_ir),
        .out_sign(a_sign), .out_scale(a_scale), .out_frac(a_frac), .out_zero(a_zero),
        .out_nar(a_nar), .out_valid(a_ov), .out_ready(a_or)
    );

    posit_decoder_pipe #(.N(16), .ES(1)) dut16 (
        .clk(clk), .rst(rst), .in_posit(b_in), .in_valid(b_iv), .in_ready(b_ir),
        .out_sign(b_sign), .out_scale(b_scale), .out_frac(b_frac), .out_zero(b_zero),
        .out_nar(b_nar), .out_valid(b_ov), .out_ready(b_or)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Walks the bits MSB-first: regime run, skip terminator, ES exponent bits, then fraction bits.
    function automatic dec_t model(input longint p, input int n, input int es);
        dec_t   d = '{default: 0};
        longint a;
        int     pos, m, e;
        bit     r;
        if (p == 0) begin
            d.zero = 1'b1;
            return d;
        end
        d.sign = p[n-1];
        if (p == (longint'(1) << (n - 1))) begin
            d.nar = 1'b1;
            return d;
        end
        a   = d.sign ? (longint'(1) << n) - p : p;
        r   = a[n-2];
        pos = n - 2;
        m   = 0;
        while (pos >= 0 && a[pos] == r) begin
            m++;
            pos--;
        end
        pos--;
        e = 0;
        for (int i = 0; i < es; i++) begin
            e = 2 * e + ((pos >= 0) ? int'(a[pos]) : 0);
            pos--;
        end
        for (int i = 0; i < n - 3 - es; i++) begin
            d.frac = 2 * d.frac + ((pos >= 0) ? longint'(a[pos]) : 0);
            pos--;
        end
        d.scale = (r ? m - 1 : -m) * (1 << es) + e;
        return d;
    endfunction

    always @(negedge clk) begin
        dec_t e;
        if (rst) begin
            q8.delete();
            held8 = 1'b0;
        end else begin
            if (held8) chk("stable8", {a_sign, a_scale, a_frac, a_zero, a_nar, a_ov}, prev8);
            chk("in_ready8", a_ir, !(q8.size() == 2 && !a_or));
            if (a_ov && a_or) begin
                if (q8.size() == 0) chk("spurious8", q8.size(), 1);
                else begin
                    e = q8.pop_front();
                    chk("sign8", a_sign, e.sign);
                    chk("scale8", longint'($signed(a_scale)), e.scale);
                    chk("frac8", longint'(a_frac), e.frac);
                    chk("zero8", a_zero, e.zero);
                    chk("nar8", a_nar, e.nar);
                    if (e.strict) chk("lat8", cyc - e.cyc, 2);
                    else chk("lat8_min", (cyc - e.cyc) >= 2, 1);
                end
            end
            if (a_iv && a_ir) begin
                e = model(longint'(a_in), 8, 0);
                e.cyc = cyc;
                e.strict = strict;
                q8.push_back(e);
            end
            held8 = a_ov && !a_or;
            prev8 = longint'({a_sign, a_scale, a_frac, a_zero, a_nar, a_ov});
        end
    end

    always @(negedge clk) begin
        dec_t e;
        if (rst) q16.delete();
        else begin
            chk("in_ready16", b_ir, !(q16.size() == 2 && !b_or));
            if (b_ov && b_or) begin
                if (q16.size() == 0) chk("spurious16", q16.size(), 1);
                else begin
                    e = q16.pop_front();
                    chk("sign16", b_sign, e.sign);
                    chk("scale16", longint'($signed(b_scale)), e.scale);
                    chk("frac16", longint'(b_frac), e.frac);
                    chk("zero16", b_zero, e.zero);
                    chk("nar16", b_nar, e.nar);
                    chk("lat16", cyc - e.cyc, 2);
                end
            end
            if (b_iv && b_ir) begin
                e = model(longint'(b_in), 16, 1);
                e.cyc = cyc;
                q16.push_back(e);
            end
        end
    end

    task automatic send8(input logic [7:0] v);
        int t = 0;
        bit acc;
        a_in = v;
        a_iv = 1'b1;
        do begin
            @(negedge clk);
            acc = a_ir;
            @(posedge clk);
            #1;
            if (rand_or) a_or = 1'($urandom_range(0, 1));
            t++;
        end while (!acc && t < 200);
        chk("accept8", acc, 1);
        a_iv = 1'b0;
    endtask

    task automatic send16(input logic [15:0] v);
        int t = 0;
        bit acc;
        b_in = v;
        b_iv = 1'b1;
        do begin
            @(negedge clk);
            acc = b_ir;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 200);
        chk("accept16", acc, 1);
        b_iv = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        a_or = 1'b1;
        while ((q8.size() != 0 || q16.size() != 0) && t < 100) begin
            @(posedge clk);
            t++;
        end
        repeat (2) @(posedge clk);
        #1;
        chk("drain8", q8.size(), 0);
        chk("drain16", q16.size(), 0);
    endtask

    task automatic pin_model(input longint p, input int n, input int es, input bit s,
                             input int sc, input longint f, input bit z, input bit nr);
        pin = model(p, n, es);
        chk("pin_sign", pin.sign, s);
        chk("pin_scale", pin.scale, sc);
        chk("pin_frac", pin.frac, f);
        chk("pin_zero", pin.zero, z);
        chk("pin_nar", pin.nar, nr);
    endtask

    initial begin
        logic [7:0]  v8[8]  = '{8'h95, 8'h01, 8'h7F, 8'h00, 8'h80, 8'h40, 8'hC0, 8'h3F};
        logic [15:0] v16[8] = '{16'h4800, 16'h7FFF, 16'h0000, 16'h8000, 16'h0001, 16'hC123, 16'h1234, 16'hFFFF};
        int t;
        rst = 1'b1;
        a_in = '0; a_iv = 1'b0; a_or = 1'b1;
        b_in = '0; b_iv = 1'b0; b_or = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ov8", a_ov, 0);
        chk("rst_data8", {a_sign, a_scale, a_frac, a_zero, a_nar}, 0);
        chk("rst_ov16", b_ov, 0);
        chk("rst_data16", {b_sign, b_scale, b_frac, b_zero, b_nar}, 0);
        #2 rst = 1'b0;

        pin_model(64'h6B, 8, 0, 0, 1, 5'b10110, 0, 0);
        pin_model(64'h95, 8, 0, 1, 1, 5'b10110, 0, 0);
        pin_model(64'h01, 8, 0, 0, -6, 0, 0, 0);
        pin_model(64'h7F, 8, 0, 0, 6, 0, 0, 0);
        pin_model(64'h00, 8, 0, 0, 0, 0, 1, 0);
        pin_model(64'h80, 8, 0, 1, 0, 0, 0, 1);
        pin_model(64'h4800, 16, 1, 0, 0, 12'h800, 0, 0);
        pin_model(64'h7FFF, 16, 1, 0, 28, 0, 0, 0);

        @(posedge clk);
        #1;
        send8(8'h6B);
        @(negedge clk);
        chk("6B_ov_early", a_ov, 0);
        @(negedge clk);
        chk("6B_ov", a_ov, 1);
        chk("6B_sign", a_sign, 0);
        chk("6B_scale", longint'($signed(a_scale)), 1);
        chk("6B_frac", a_frac, 5'b10110);
        chk("6B_zn", {a_zero, a_nar}, 0);
        @(posedge clk);
        #1;

        foreach (v8[i]) send8(v8[i]);
        foreach (v16[i]) send16(v16[i]);
        drain();

        strict = 1'b0;
        rand_or = 1'b1;
        for (int v = 1; v <= 16; v++) send8(8'(v));
        rand_or = 1'b0;
        drain();

        strict = 1'b1;
        a_or = 1'b0;
        send8(8'h21);
        send8(8'h22);
        t = 0;
        while (a_ir && t < 20) begin
            @(posedge clk);
            #1;
            t++;
        end
        chk("full_in_ready", a_ir, 0);
        chk("full_ov", a_ov, 1);
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        chk("mid_rst_ov", a_ov, 0);
        chk("mid_rst_data", {a_sign, a_scale, a_frac, a_zero, a_nar}, 0);
        chk("mid_rst_in_ready", a_ir, 1);
        @(posedge clk);
        #3 rst = 1'b0;
        a_or = 1'b1;
        @(posedge clk);
        #1;
        send8(8'h4C);
        @(negedge clk);
        chk("post_rst_ov_early", a_ov, 0);
        @(negedge clk);
        chk("post_rst_ov", a_ov, 1);
        chk("post_rst_scale", longint'($signed(a_scale)), 0);
        chk("post_rst_frac", a_frac, 5'b01100);
        drain();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule

// File: doc/posit_decoder_pipe.md
Name: posit_decoder_pipe

Overview:
- Parametrised, pipelined posit field decoder. Successor to the 8-bit combinational regime shifter.
- Accepts an N-bit posit with ES exponent bits and produces sign, scale, left-aligned fraction, zero flag and NaR flag.
- Negative posits are two's-complemented before decoding.
- Sits at the front of the posit arithmetic datapath and feeds unpacked operands to the adder/multiplier stages through a valid/ready handshake.

Parameters:
- N, 8, posit width in bits; N >= 5.
- ES, 0, exponent field width; 0 <= ES <= N-5.
- FW (localparam), N-3-ES, fraction output width.
- SW (localparam), $clog2(N)+ES+1, signed scale output width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_posit  in  N  posit operand.
- in_valid  in  1  in_posit is valid.
- in_ready  out  1  block accepts in_posit this cycle.
- out_sign  out  1  posit sign bit.
- out_scale  out  SW  signed scale, regime*2^ES + exponent.
- out_frac  out  FW  fraction bits below the hidden 1, MSB-aligned.
- out_zero  out  1  operand was 0.
- out_nar  out  1  operand was NaR (1 followed by all zeros).
- out_valid  out  1  output fields valid.
- out_ready  in  1  downstream accepts the output.

Behaviour:
- Clock and reset: single clock domain. While rst is high, s1_valid, out_valid and all out_* data registers are 0.
- Reset mid-operation: any in-flight operands are discarded. No output is produced for them after rst falls.
- Pipeline: two register stages.
  - S1 registers the sign, the absolute value (two's complement when the sign is 1), is_zero and is_nar.
  - S2 registers the decoded fields.
  - Latency is 2 cycles from accept to out_valid when out_ready is held high.
  - Throughput is 1 operand per cycle.
- Handshake:
  - A transfer occurs when valid and ready are both high.
  - s2_adv = ~out_valid | out_ready.
  - s1_adv = ~s1_valid | s2_adv.
  - in_ready = s1_adv, purely combinational from registered state and out_ready. No combinational path from in_valid to in_ready.
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - in_valid may drop at any time without a transfer. No skid buffer is required.
- Regime decode (on the absolute value a):
  - r = a[N-2]. m = length of the run of bits equal to r, starting at bit N-2, with 1 <= m <= N-1.
  - k = m-1 if r=1, otherwise k = -m.
  - The terminator is the first differing bit below the run; it is absent when m = N-1.
- Exponent: the ES bits following the terminator, MSB first. Bits that fall off the LSB end are taken as 0.
- Fraction: the remaining bits, left-aligned into out_frac and zero-padded on the right.
- Scale: out_scale = k*2^ES + exponent, computed in SW bits, two's complement. Overflow is impossible by construction.
- Special cases:
  - Zero (in_posit == 0): out_zero=1, sign=0, scale=0, frac=0, nar=0.
  - NaR (MSB=1, rest 0): out_nar=1, sign=1, scale=0, frac=0, zero=0.
  - out_zero and out_nar are never both 1.
- Run-length detection is a priority/leading-run encoder generalised to N. Hard-coded 8-bit selectors are not allowed.

Test Plan:
- N=8, ES=0, in_posit=8'h6B, out_ready=1: 2 cycles later out_valid=1, sign=0, scale=+1, frac=5'b10110, zero=0, nar=0.
- N=8, ES=0 extremes:
  - 8'h95: sign=1, scale=+1, frac=5'b10110.
  - 8'h01: scale=-6, frac=0.
  - 8'h7F (no terminator): scale=+6, frac=0.
  - 8'h00: zero=1.
  - 8'h80: nar=1, sign=1.
- N=16, ES=1, in_posit=16'h4800: scale=0, frac=12'h800.
- N=16, ES=1, in_posit=16'h7FFF (exponent bits truncated to 0): scale=+28, frac=0.
- Backpressure, N=8, ES=0:
  - Stream 8'h01..8'h10 back-to-back with out_ready toggling randomly.
  - Required: every operand is delivered once, in order, with no loss or duplication.
  - Required: out_* are stable while stalled, and in_ready=0 only when both stages are full and out_ready=0.
- Reset mid-stream: assert rst asynchronously with both stages full. Required: out_valid drops to 0 immediately with no clock edge, all outputs read 0, and the first post-reset operand emerges 2 cycles after its acceptance.
